exception_sequencer: RTL and testbench

- Multicycle sequencer that takes the CPU from "error flag raised" to "PC loaded with handler address".
- Arbitrates the three error sources by fixed priority and writes EPC.
- Drives a vector-table read at bytes 253/254/255 through the shared memory port, then writes the PC from the returned byte.
- Sits beside the main control FSM, which stalls while `exc_busy` is high and cedes memory/PC/EPC write ownership to this block.

---
 rtl/exception_sequencer_pkg.sv | 45 ++++
 rtl/exception_sequencer_if.sv | 76 +++++++
 rtl/exception_sequencer_priority_enc.sv | 36 +++
 rtl/exception_sequencer.sv | 168 ++++++++++++++++
 tb/tb_exception_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exception_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : exc_pkg
//  Purpose  : Shared types and constants for the exception sequencer and for
//             the main control FSM that cooperates with it: sequencer state
//             encoding, exception cause codes, vector-table byte addresses
//             and a helper that maps a cause code to its vector address.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package exc_pkg;

  // Sequencer states. The encoding width is fixed so that it matches the
  // state register declared in the sequencer.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    LOAD_PC  = 3'd4
  } exc_state_t;

  // Cause codes as reported on exc_cause. Code 0 means "no exception".
  localparam logic [1:0] EXC_NONE   = 2'd0;
  localparam logic [1:0] EXC_OPCODE = 2'd1;
  localparam logic [1:0] EXC_OVF    = 2'd2;
  localparam logic [1:0] EXC_DIV0   = 2'd3;

  // Vector-table byte addresses, one byte per cause, contiguous.
  localparam logic [31:0] VEC_ADDR_OPCODE = 32'd253;
  localparam logic [31:0] VEC_ADDR_OVF    = 32'd254;
  localparam logic [31:0] VEC_ADDR_DIV0   = 32'd255;

  // Width of the memory-latency wait counter: holds MEM_LATENCY-1 (max 6).
  localparam int unsigned WAIT_CNT_W = 3;

  // Vector address for a cause: base points at the opcode entry, the other
  // causes follow it in code order. Only meaningful for cause != EXC_NONE.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [1:0]  cause);
    return base + {30'd0, cause} - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exception_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : exception_sequencer_if
//  Purpose  : Bundle of every signal exchanged between the exception
//             sequencer and the rest of the CPU (error flags, PC source,
//             shared memory port, PC/EPC write port, status).
//  Modports : master - the exception sequencer (drives memory/PC/EPC port)
//             slave  - the CPU side (error flags, memory data, consumers)
//  Optional : EXC_COUNT_EN adds the 16-bit exc_count status signal.
//  Revision : 1.0 - initial release
// ============================================================================
interface exception_sequencer_if;

  // CPU -> sequencer
  logic        exc_mask;
  logic        opcode_error;
  logic        overflow_error;
  logic        div_zero_error;
  logic [31:0] pc_current;
  logic [31:0] mem_rdata;

  // sequencer -> CPU
  logic        exc_busy;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        epc_write;
  logic [31:0] epc_data;
  logic        pc_write;
  logic [31:0] pc_data;
  logic [1:0]  exc_cause;
`ifdef EXC_COUNT_EN
  logic [15:0] exc_count;
`endif

  modport master (
`ifdef EXC_COUNT_EN
    output exc_count,
`endif
    input  exc_mask,
    input  opcode_error,
    input  overflow_error,
    input  div_zero_error,
    input  pc_current,
    input  mem_rdata,
    output exc_busy,
    output mem_addr,
    output mem_read,
    output epc_write,
    output epc_data,
    output pc_write,
    output pc_data,
    output exc_cause
  );

  modport slave (
`ifdef EXC_COUNT_EN
    input  exc_count,
`endif
    output exc_mask,
    output opcode_error,
    output overflow_error,
    output div_zero_error,
    output pc_current,
    output mem_rdata,
    input  exc_busy,
    input  mem_addr,
    input  mem_read,
    input  epc_write,
    input  epc_data,
    input  pc_write,
    input  pc_data,
    input  exc_cause
  );

endinterface
`default_nettype wire

// File: rtl/exception_sequencer_priority_enc.sv
`default_nettype none
// ============================================================================
//  Module   : exc_priority_enc
//  Purpose  : Combinational fixed-priority encoder for the three error flags.
//             opcode > overflow > div-zero; lower-priority flags raised in
//             the same cycle are simply not reported.
//  Ports    : opcode_error, overflow_error, div_zero_error - error flags
//             cause - EXC_* cause code (EXC_NONE when no flag is set)
//             valid - at least one flag is set
//  Revision : 1.0 - initial release
// ============================================================================
module exc_priority_enc
  import exc_pkg::*;
(
  input  logic       opcode_error,
  input  logic       overflow_error,
  input  logic       div_zero_error,
  output logic [1:0] cause,
  output logic       valid
);

  always_comb begin
    cause = EXC_NONE;
    if (opcode_error) begin
      cause = EXC_OPCODE;
    end else if (overflow_error) begin
      cause = EXC_OVF;
    end else if (div_zero_error) begin
      cause = EXC_DIV0;
    end
  end

  assign valid = (cause != EXC_NONE);

endmodule
`default_nettype wire

// File: rtl/exception_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : exception_sequencer
//  Purpose  : Multicycle sequencer taking the CPU from a raised error flag to
//             the PC loaded with the handler address: arbitrates the error
//             sources, writes EPC, reads the handler byte from the vector
//             table through the shared memory port, then writes the PC.
//  Ports    : clk     - system clock, rising edge
//             reset_n - asynchronous active-low reset
//             bus     - exception_sequencer_if.master (error flags, PC source,
//                       memory port, PC/EPC write port, busy/cause status)
//  Params   : MEM_LATENCY (1..7) cycles from mem_read to valid mem_rdata
//             EPC_OFFSET  subtracted from pc_current to form EPC
//             VEC_BASE    vector byte address of the opcode-error entry
//  Optional : EXC_COUNT_EN adds a saturating 16-bit count of exceptions taken
//             (bus.exc_count).
//  Revision : 1.0 - initial release
// ============================================================================
module exception_sequencer
  import exc_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [31:0] EPC_OFFSET  = 32'd4,
  parameter logic [31:0] VEC_BASE    = VEC_ADDR_OPCODE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  exception_sequencer_if.master bus
);

  // The counter is preloaded with MEM_LATENCY-1 and MEM_WAIT exits on zero,
  // so MEM_WAIT lasts exactly MEM_LATENCY cycles and mem_rdata is sampled in
  // the MEM_LATENCY-th cycle after mem_read first rose (in MEM_REQ).
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(MEM_LATENCY - 1);

  exc_state_t            state_q,    state_d;
  logic [1:0]            cause_q,    cause_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [31:0]           epc_data_q, epc_data_d;
  logic [31:0]           pc_data_q,  pc_data_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [1:0] enc_cause;
  logic       enc_valid;
  logic       take_exc;

  // Only the low byte of the vector-table read carries the handler address.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^bus.mem_rdata[31:8];

  exc_priority_enc u_prio (
    .opcode_error   (bus.opcode_error),
    .overflow_error (bus.overflow_error),
    .div_zero_error (bus.div_zero_error),
    .cause          (enc_cause),
    .valid          (enc_valid)
  );

  // Flags and mask are only looked at in IDLE, which is what prevents nesting.
  assign take_exc = (state_q == IDLE) && !bus.exc_mask && enc_valid;

  // --------------------------------------------------------------------------
  // Next-state and datapath capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    mem_addr_d = mem_addr_q;
    epc_data_d = epc_data_q;
    pc_data_d  = pc_data_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (take_exc) begin
          state_d    = CAPTURE;
          cause_d    = enc_cause;
          mem_addr_d = vec_addr(VEC_BASE, enc_cause);
          // Plain 32-bit subtraction: wraps below zero by design.
          epc_data_d = bus.pc_current - EPC_OFFSET;
        end
      end

      CAPTURE: begin
        state_d = MEM_REQ;
      end

      MEM_REQ: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = MEM_WAIT;
      end

      MEM_WAIT: begin
        if (wait_cnt_q == '0) begin
          pc_data_d = {24'd0, bus.mem_rdata[7:0]};
          state_d   = LOAD_PC;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end

      LOAD_PC: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cause_q    <= EXC_NONE;
      mem_addr_q <= '0;
      epc_data_q <= '0;
      pc_data_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      mem_addr_q <= mem_addr_d;
      epc_data_q <= epc_data_d;
      pc_data_q  <= pc_data_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: strobes decode straight from the state register, so a reset
  // clears them immediately and EPC/PC writes can never overlap.
  // --------------------------------------------------------------------------
  assign bus.exc_busy  = (state_q != IDLE);
  assign bus.epc_write = (state_q == CAPTURE);
  assign bus.mem_read  = (state_q == MEM_REQ) || (state_q == MEM_WAIT);
  assign bus.pc_write  = (state_q == LOAD_PC);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.epc_data  = epc_data_q;
  assign bus.pc_data   = pc_data_q;
  assign bus.exc_cause = cause_q;

`ifdef EXC_COUNT_EN
  // --------------------------------------------------------------------------
  // Saturating count of exceptions taken (one per CAPTURE entry).
  // --------------------------------------------------------------------------
  logic [15:0] exc_count_q, exc_count_d;

  always_comb begin
    exc_count_d = exc_count_q;
    if (take_exc && (exc_count_q != 16'hFFFF)) begin
      exc_count_d = exc_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exc_count_q <= '0;
    end else begin
      exc_count_q <= exc_count_d;
    end
  end

  assign bus.exc_count = exc_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exception_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exception_sequencer
//  Purpose  : Self-checking bench for exception_sequencer. A timeline model
//             (cycle offsets from the taking edge) predicts every output and
//             is compared on each falling edge; directed scenarios add
//             hand-computed literal checks. A small memory responder returns
//             the vector byte only in the cycle the data is due.
//  Optional : EXC_COUNT_EN selects MEM_LATENCY=4 and checks exc_count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exception_sequencer;

`ifdef EXC_COUNT_EN
  localparam int LAT     = 4;
  localparam int PCW_CYC = 7;
`else
  localparam int LAT     = 2;
  localparam int PCW_CYC = 5;
`endif

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  exception_sequencer_if bus ();

  exception_sequencer #(.MEM_LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Vector table contents; upper bytes are deliberately non-zero on some
  // entries because only the low byte may reach pc_data.
  function automatic logic [31:0] table_word(input logic [31:0] a);
    case (a)
      32'd253: return 32'h000000A0;
      32'd254: return 32'h7F0000B4;
      32'd255: return 32'hFF0000C8;
      default: return 32'h00000000;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Memory responder: data valid only in the LAT-th cycle after mem_read rose.
  // --------------------------------------------------------------------------
  int rd_cnt;
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt        <= 0;
      bus.mem_rdata <= 32'hEEEEEE3C;
    end else begin
      if (bus.mem_read) begin
        rd_cnt        <= rd_cnt + 1;
        bus.mem_rdata <= (rd_cnt + 1 == LAT + 1) ? table_word(bus.mem_addr) : 32'hEEEEEE3C;
      end else begin
        rd_cnt        <= 0;
        bus.mem_rdata <= 32'hEEEEEE3C;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Behavioural model: m_rel counts edges since the taking edge (1 = first
  // cycle of the sequence). The sequence occupies cycles 1 .. 3+LAT.
  // --------------------------------------------------------------------------
  bit          m_active;
  int          m_rel;
  logic [1:0]  m_cause;
  logic [31:0] m_addr, m_epc, m_pc;
  logic [15:0] m_count;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 0;
      m_rel    <= 0;
      m_cause  <= 2'd0;
      m_addr   <= 32'd0;
      m_epc    <= 32'd0;
      m_pc     <= 32'd0;
      m_count  <= 16'd0;
    end else if (m_active) begin
      if (m_rel == 3 + LAT) begin
        m_active <= 0;
      end else begin
        m_rel <= m_rel + 1;
        if (m_rel + 1 == 3 + LAT) m_pc <= {24'd0, table_word(m_addr)[7:0]};
      end
    end else if (!bus.exc_mask &&
                 (bus.opcode_error || bus.overflow_error || bus.div_zero_error)) begin
      m_active <= 1;
      m_rel    <= 1;
      m_cause  <= bus.opcode_error ? 2'd1 : (bus.overflow_error ? 2'd2 : 2'd3);
      m_addr   <= bus.opcode_error ? 32'd253 : (bus.overflow_error ? 32'd254 : 32'd255);
      m_epc    <= bus.pc_current - 32'd4;
      m_count  <= (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
    end
  end

  // Compare process: every falling edge once the DUT has seen a clocked reset.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",      {31'd0, bus.exc_busy},  {31'd0, m_active});
      chk("epc_write", {31'd0, bus.epc_write}, {31'd0, m_active && m_rel == 1});
      chk("mem_read",  {31'd0, bus.mem_read},  {31'd0, m_active && m_rel >= 2 && m_rel <= 2 + LAT});
      chk("pc_write",  {31'd0, bus.pc_write},  {31'd0, m_active && m_rel == 3 + LAT});
      chk("mem_addr",  bus.mem_addr,  m_addr);
      chk("epc_data",  bus.epc_data,  m_epc);
      chk("pc_data",   bus.pc_data,   m_pc);
      chk("exc_cause", {30'd0, bus.exc_cause}, {30'd0, m_cause});
`ifdef EXC_COUNT_EN
      chk("exc_count", {16'd0, bus.exc_count}, {16'd0, m_count});
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  int pcw;

  initial begin
    reset_n            = 1'b0;
    bus.exc_mask       = 1'b0;
    bus.opcode_error   = 1'b0;
    bus.overflow_error = 1'b0;
    bus.div_zero_error = 1'b0;
    bus.pc_current     = 32'd0;
    @(posedge clk);
    #1 chk_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'd0, bus.exc_busy}, 32'd0);
    chk("rst_cause", {30'd0, bus.exc_cause}, 32'd0);
    chk("rst_pc",    bus.pc_data, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: opcode error, pc 0x40
    bus.opcode_error = 1'b1;
    bus.pc_current   = 32'h40;
    for (int c = 1; c <= PCW_CYC; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.opcode_error = 1'b0;
        chk("t1_epc_write", {31'd0, bus.epc_write}, 32'd1);
        chk("t1_epc_data",  bus.epc_data, 32'h3C);
        chk("t1_mem_addr",  bus.mem_addr, 32'd253);
        chk("t1_cause",     {30'd0, bus.exc_cause}, 32'd1);
      end
      chk("t1_pc_write", {31'd0, bus.pc_write}, (c == PCW_CYC) ? 32'd1 : 32'd0);
    end
    chk("t1_pc_data", bus.pc_data, 32'hA0);
    repeat (3) @(negedge clk);

    // 2: all three errors at once
    bus.opcode_error   = 1'b1;
    bus.overflow_error = 1'b1;
    bus.div_zero_error = 1'b1;
    bus.pc_current     = 32'h100;
    @(negedge clk);
    bus.opcode_error   = 1'b0;
    bus.overflow_error = 1'b0;
    bus.div_zero_error = 1'b0;
    chk("t2_cause",    {30'd0, bus.exc_cause}, 32'd1);
    chk("t2_mem_addr", bus.mem_addr, 32'd253);
    chk("t2_epc_data", bus.epc_data, 32'hFC);
    repeat (LAT + 5) @(negedge clk);

    // 3: masked div-zero for 10 cycles; mask and error rise together
    bus.exc_mask       = 1'b1;
    bus.div_zero_error = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t3_busy",      {31'd0, bus.exc_busy},  32'd0);
      chk("t3_epc_write", {31'd0, bus.epc_write}, 32'd0);
      chk("t3_pc_write",  {31'd0, bus.pc_write},  32'd0);
    end
    bus.div_zero_error = 1'b0;
    bus.exc_mask       = 1'b0;
    repeat (2) @(negedge clk);

    // 4: overflow pulse, then div-zero raised during MEM_WAIT
    bus.overflow_error = 1'b1;
    bus.pc_current     = 32'h200;
    pcw = 0;
    for (int c = 1; c <= LAT + 9; c++) begin
      @(negedge clk);
      if (bus.pc_write) pcw++;
      if (c == 1) begin
        bus.overflow_error = 1'b0;
        chk("t4_cause",    {30'd0, bus.exc_cause}, 32'd2);
        chk("t4_mem_addr", bus.mem_addr, 32'd254);
      end
      if (c == 3) bus.div_zero_error = 1'b1;
      if (c == 3 + LAT) bus.div_zero_error = 1'b0;
    end
    chk("t4_pc_write_count", pcw, 32'd1);
    chk("t4_pc_data", bus.pc_data, 32'hB4);
    chk("t4_mem_addr_hold", bus.mem_addr, 32'd254);

    // 5: reset in MEM_WAIT, then pc_current=0 wraps EPC
    bus.opcode_error = 1'b1;
    bus.pc_current   = 32'h80;
    repeat (3) @(negedge clk);
    bus.opcode_error = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_busy",     {31'd0, bus.exc_busy}, 32'd0);
    chk("t5_rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("t5_rst_mem_addr", bus.mem_addr, 32'd0);
    chk("t5_rst_epc_data", bus.epc_data, 32'd0);
    chk("t5_rst_cause",    {30'd0, bus.exc_cause}, 32'd0);
    repeat (2) @(negedge clk);
`ifdef EXC_COUNT_EN
    chk("t5_rst_count", {16'd0, bus.exc_count}, 32'd0);
`endif
    reset_n = 1'b1;
    pcw = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.pc_write) pcw++;
    end
    chk("t5_no_pc_write", pcw, 32'd0);
    bus.overflow_error = 1'b1;
    bus.pc_current     = 32'd0;
    @(negedge clk);
    bus.overflow_error = 1'b0;
    chk("t5_epc_wrap", bus.epc_data, 32'hFFFFFFFC);
    repeat (LAT + 4) @(negedge clk);
    chk("t5_pc_data", bus.pc_data, 32'hB4);
`ifdef EXC_COUNT_EN
    chk("t5_count1", {16'd0, bus.exc_count}, 32'd1);
`endif

    // 6: div-zero sequence, pc_write exactly PCW_CYC cycles after trigger
    bus.div_zero_error = 1'b1;
    bus.pc_current     = 32'h1000;
    for (int c = 1; c <= PCW_CYC; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.div_zero_error = 1'b0;
        chk("t6_mem_addr", bus.mem_addr, 32'd255);
        chk("t6_epc_data", bus.epc_data, 32'hFFC);
      end
      chk("t6_pc_write", {31'd0, bus.pc_write}, (c == PCW_CYC) ? 32'd1 : 32'd0);
    end
    chk("t6_pc_data", bus.pc_data, 32'hC8);
    chk("t6_cause",   {30'd0, bus.exc_cause}, 32'd3);
`ifdef EXC_COUNT_EN
    chk("t6_count2", {16'd0, bus.exc_count}, 32'd2);
`endif
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
